stack_arbiter: RTL
==================

# stack_arbiter

Two-port arbiter that shares one LIFO stack between two requesters. It takes level-held push/pop requests and grants them round-robin. It drives the stack's push/pop/data strobes and returns popped words to the winning requester. Requests that would overflow or underflow the stack are rejected with an error pulse, and the stack is never strobed for them. The block sits between the client logic and the stack storage, and both run on the same clock and reset.

## Interface
- WIDTH, 32, data word width (matches stack data/out width)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0_push / req1_push  in  1  push request, held until ack
- req0_pop / req1_pop  in  1  pop request, held until ack
- req0_data / req1_data  in  WIDTH  push word, stable while push held
- ack0 / ack1  out  1  one-cycle pulse: request consumed (accepted or rejected)
- err0 / err1  out  1  one-cycle pulse coincident with ack: request rejected
- rdata0 / rdata1  out  WIDTH  last popped word for that requester, held until next pop
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN updated
- stk_push  out  1  push strobe to stack, one cycle
- stk_pop  out  1  pop strobe to stack, one cycle
- stk_data  out  WIDTH  word to push, valid with stk_push
- stk_out  in  WIDTH  stack top output, valid the cycle after stk_pop
- stk_empty, stk_full  in  1  stack status flags

## Operation
- FSM states:
  - IDLE: sample requests and flags, arbitrate, latch grant/op/data.
  - ISSUE: drive stk_push or stk_pop, or neither if rejected. Pulse ackN, plus errN if rejected.
  - RDATA: pop only. Capture stk_out into rdataN.
- Transitions: IDLE→ISSUE when any request is pending. ISSUE→RDATA for an accepted pop, else ISSUE→IDLE. RDATA→IDLE always.
- Request of a requester = reqN_push | reqN_pop. If both are high in the same cycle, it is a protocol error: grant normally, then reject with errN and no stack strobe.
- Round-robin: a 1-bit pointer holds the last granted requester.
  - With both requesting, grant the other one.
  - With one requesting, grant it and update the pointer.
  - After reset the pointer favours req0.
- Reject rules, evaluated on flags sampled in IDLE:
  - push with stk_full=1 → err.
  - pop with stk_empty=1 → err.
  - Rejected ops do not touch the stack or rdataN.
- stk_data is driven from the latched push word, and is 0 when not pushing.
- Only this block strobes the stack, so the flags sampled in IDLE stay valid through ISSUE.
- Reset: state=IDLE, pointer=req1 (so req0 wins the first tie), and all outputs 0:
  - stk_push, stk_pop, stk_data
  - ackN, errN, rvalidN, rdataN
- Reset mid-operation aborts with no ack and no rvalid. The stack shares rst, so it is cleared too.

## Timing
- Request sampled in IDLE at cycle T. ISSUE is at T+1: strobe and ackN high during T+1.
- Requester drops or changes its request in the cycle after ack. A request still held at the next IDLE is a new operation.
- Push: stack updates at the end of T+1, next IDLE at T+2. Throughput is 1 push per 2 cycles.
- Pop: stk_out is valid at T+2 (RDATA) and registered into rdataN. rvalidN pulses at T+3, the same cycle as the next IDLE. Throughput is 1 pop per 3 cycles.
- Reject: errN and ackN pulse at T+1 with no strobe, next IDLE at T+2.
- The non-granted requester waits. It is served at the next IDLE if still requesting, so the worst-case wait is one foreign operation.
- Outputs are registered, with no combinational path from reqN_* to stk_*.

## Test plan
- Reset, then req0 pushes 32'hABCD, 32'h1234, 32'h2345 in sequence.
  - Expect three ack0 pulses, each 1 cycle after IDLE sampling.
  - stk_push with stk_data equal to each word in order.
  - No err0.
- req1 pops three times after that sequence.
  - rdata1/rvalid1 deliver 32'h2345, 32'h1234, 32'h ABCD, each with rvalid1 3 cycles after sampling.
  - A fourth pop, with stk_empty=1, gives ack1+err1, no stk_pop and rdata1 unchanged (32'hABCD).
- req0 and req1 both hold push continuously (data 32'h1, 32'h2) from reset release.
  - Grants alternate 0,1,0,1; the first goes to req0.
  - The stk_data sequence is 1,2,1,2.
- Drive stk_full=1 and request a push from req0 → ack0+err0 at T+1, stk_push stays 0.
- req1 asserts push and pop together → ack1+err1, no stack strobe.
- Assert rst during RDATA of a pop → next cycle state IDLE, all outputs 0, no rvalid pulse.

Source files
------------

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin arbiter sharing one LIFO stack between two requesters
// Grants level-held push/pop requests and rejects overflow, underflow and push+pop conflicts.
module stack_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_push,
  input  logic             req0_pop,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_push,
  input  logic             req1_pop,
  input  logic [WIDTH-1:0] req1_data,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_out,
  input  logic             stk_empty,
  input  logic             stk_full
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic             gnt;
  logic             op_pop;

  logic             any0;
  logic             any1;
  logic             pick;
  logic             sel_push;
  logic             sel_pop;
  logic [WIDTH-1:0] sel_data;
  logic             bad;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    any0     = req0_push | req0_pop;
    any1     = req1_push | req1_pop;
    // ptr holds the last winner, so a tie goes to the other requester
    pick     = (any0 & any1) ? ~ptr : any1;
    sel_push = pick ? req1_push : req0_push;
    sel_pop  = pick ? req1_pop  : req0_pop;
    sel_data = pick ? req1_data : req0_data;
    bad      = (sel_push & sel_pop) | (sel_push & stk_full) | (sel_pop & stk_empty);
    do_push  = sel_push & ~bad;
    do_pop   = sel_pop & ~bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b1;
      gnt      <= 1'b0;
      op_pop   <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_data <= '0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_data <= '0;
      case (state)
        IDLE: begin
          if (any0 | any1) begin
            gnt      <= pick;
            ptr      <= pick;
            op_pop   <= do_pop;
            ack0     <= ~pick;
            ack1     <= pick;
            err0     <= ~pick & bad;
            err1     <= pick & bad;
            stk_push <= do_push;
            stk_pop  <= do_pop;
            stk_data <= do_push ? sel_data : '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= op_pop ? RDATA : IDLE;
        end
        RDATA: begin
          // stk_out reflects the pop issued in the previous cycle
          if (gnt) begin
            rdata1  <= stk_out;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= stk_out;
            rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
